// File: rtl/tt_um_erickespa_sender.sv
// Serial code transmitter: shifts a 1-8 bit code LSB first on a valid/bit pair,
// then collects the checker's verdict (approved, rejected or timeout).
module tt_um_erickespa_sender #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEND, S_GAP, S_WAIT, S_DONE
   } state_t;

   localparam logic [3:0] TMO = 4'(TIMEOUT);

   state_t     state, state_n;
   logic       start_q;
   logic [7:0] code, code_n;
   logic [3:0] len, len_n;
   logic [2:0] idx, idx_n, idx_inc;
   logic [3:0] tcnt, tcnt_n, tcnt_inc;
   logic       tx_v, tx_v_n, tx_d, tx_d_n;
   logic       busy, busy_n, done, done_n;
   logic [1:0] result, result_n, rej_cnt, rej_cnt_n;
   logic       start_ev;
   logic [1:0] resp;
   logic       unused_ok;

   assign start_ev  = uio_in[7] & ~start_q;
   assign resp      = uio_in[1:0];
   assign idx_inc   = idx + 3'd1;
   assign tcnt_inc  = tcnt + 4'd1;
   assign unused_ok = &{1'b0, ena, uio_in[3:2]};

   always_comb begin
      state_n   = state;
      code_n    = code;
      len_n     = len;
      idx_n     = idx;
      tcnt_n    = tcnt;
      tx_v_n    = tx_v;
      tx_d_n    = tx_d;
      busy_n    = busy;
      done_n    = done;
      result_n  = result;
      rej_cnt_n = rej_cnt;
      case (state)
         S_IDLE, S_DONE: begin
            // rej_cnt is deliberately kept across frames
            if (start_ev) begin
               state_n  = S_SEND;
               code_n   = ui_in;
               len_n    = {1'b0, uio_in[6:4]} + 4'd1;
               idx_n    = 3'd0;
               tx_v_n   = 1'b1;
               tx_d_n   = ui_in[0];
               busy_n   = 1'b1;
               done_n   = 1'b0;
               result_n = 2'b00;
            end
         end
         S_SEND: begin
            if ({1'b0, idx} == len - 4'd1) begin
               state_n = S_GAP;
               tx_v_n  = 1'b0;
               tx_d_n  = 1'b0;
            end else begin
               idx_n  = idx_inc;
               tx_d_n = code[idx_inc];
            end
         end
         S_GAP, S_WAIT: begin
            // A verdict beats a timeout landing on the same edge
            if (resp == 2'b11) begin
               state_n   = S_DONE;
               result_n  = 2'b11;
               rej_cnt_n = 2'b00;
               busy_n    = 1'b0;
               done_n    = 1'b1;
            end else if (resp == 2'b10) begin
               state_n   = S_DONE;
               result_n  = 2'b10;
               rej_cnt_n = (rej_cnt == 2'b11) ? 2'b11 : rej_cnt + 2'b01;
               busy_n    = 1'b0;
               done_n    = 1'b1;
            end else if (state == S_GAP) begin
               state_n = S_WAIT;
               tcnt_n  = 4'd0;
            end else if (tcnt_inc == TMO) begin
               state_n  = S_DONE;
               result_n = 2'b01;
               busy_n   = 1'b0;
               done_n   = 1'b1;
            end else begin
               tcnt_n = tcnt_inc;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         start_q <= 1'b0;
         code    <= 8'd0;
         len     <= 4'd0;
         idx     <= 3'd0;
         tcnt    <= 4'd0;
         tx_v    <= 1'b0;
         tx_d    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= 2'b00;
         rej_cnt <= 2'b00;
      end else begin
         state   <= state_n;
         start_q <= uio_in[7];
         code    <= code_n;
         len     <= len_n;
         idx     <= idx_n;
         tcnt    <= tcnt_n;
         tx_v    <= tx_v_n;
         tx_d    <= tx_d_n;
         busy    <= busy_n;
         done    <= done_n;
         result  <= result_n;
         rej_cnt <= rej_cnt_n;
      end
   end

   assign uo_out  = {rej_cnt, result, done, busy, tx_d, tx_v};
   assign uio_out = 8'd0;
   assign uio_oe  = 8'd0;

endmodule

// File: tb/tb_tt_um_erickespa_sender.sv
// Bench for tt_um_erickespa_sender: expected bits queued at start, popped while
// tx_v is high; verdict, rej_cnt and latency checked against a small model.
module tb_tt_um_erickespa_sender;

   localparam int TIMEOUT = 15;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic       start;
   logic [2:0] len_m1;
   logic [1:0] resp;
   logic [7:0] uio_in;
   logic [7:0] uo_out, uio_out, uio_oe;
   logic       tx_v, tx_d, busy, done;
   logic [1:0] result, rej_cnt;

   logic       exp_q[$];
   logic [1:0] rej_model;
   int         tests = 0;
   int         fails = 0;

   assign uio_in  = {start, len_m1, 2'b00, resp};
   assign tx_v    = uo_out[0];
   assign tx_d    = uo_out[1];
   assign busy    = uo_out[2];
   assign done    = uo_out[3];
   assign result  = uo_out[5:4];
   assign rej_cnt = uo_out[7:6];

   tt_um_erickespa_sender #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   task automatic send_frame(input logic [7:0] c, input logic [2:0] lm1,
                             input logic [1:0] verdict, input int delay,
                             input bit glitch, input bit hold);
      int n_valid;
      int waits;
      int exp_waits;
      logic bit_exp;
      logic [1:0] exp_res;
      ui_in  = c;
      len_m1 = lm1;
      resp   = 2'b00;
      start  = 1'b1;
      for (int i = 0; i <= int'(lm1); i++) exp_q.push_back(c[i]);
      @(negedge clk);
      if (!hold) start = 1'b0;
      n_valid = 0;
      while (tx_v === 1'b1 && n_valid < 12) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL extra_valid: tx_v high with no bit expected (cycle %0d)", n_valid);
         end else begin
            bit_exp = exp_q.pop_front();
            if (tx_d !== bit_exp) begin
               fails++;
               $display("FAIL tx_d bit %0d: got %b expected %b", n_valid, tx_d, bit_exp);
            end
         end
         tests++;
         if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_send: got %b expected 1", busy);
         end
         n_valid++;
         if (glitch && n_valid == 2) begin
            start  = 1'b1;
            ui_in  = ~c;
            len_m1 = ~lm1;
         end else if (glitch && n_valid == 3) begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      tests++;
      if (n_valid != int'(lm1) + 1) begin
         fails++;
         $display("FAIL frame_len: got %0d valid cycles expected %0d", n_valid, int'(lm1) + 1);
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL missing_bits: %0d bits never sent", exp_q.size());
         exp_q.delete();
      end
      repeat (delay) @(negedge clk);
      resp  = verdict;
      waits = 0;
      while (done !== 1'b1 && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      exp_waits = verdict[1] ? 1 : TIMEOUT + 1 - delay;
      if (verdict == 2'b11) rej_model = 2'b00;
      else if (verdict == 2'b10 && rej_model != 2'b11) rej_model = rej_model + 2'b01;
      exp_res = verdict[1] ? verdict : 2'b01;
      tests++;
      if (waits != exp_waits) begin
         fails++;
         $display("FAIL done_latency: got %0d cycles expected %0d", waits, exp_waits);
      end
      tests++;
      if (result !== exp_res) begin
         fails++;
         $display("FAIL result: got %b expected %b", result, exp_res);
      end
      tests++;
      if (rej_cnt !== rej_model) begin
         fails++;
         $display("FAIL rej_cnt: got %0d expected %0d", rej_cnt, rej_model);
      end
      tests++;
      if (busy !== 1'b0 || tx_v !== 1'b0) begin
         fails++;
         $display("FAIL done_flags: got busy=%b tx_v=%b expected 0 0", busy, tx_v);
      end
      resp = 2'b00;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (uo_out !== 8'h00) begin
         fails++;
         $display("FAIL reset_uo: got %h expected 00", uo_out);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests++;
         if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            fails++;
            $display("FAIL idle_outputs: got uo=%h uio_out=%h uio_oe=%h expected 00 00 00",
                     uo_out, uio_out, uio_oe);
         end
      end
   endtask

   task automatic test_approve_2bit();
      send_frame(8'h03, 3'd1, 2'b11, 2, 1'b0, 1'b0);
   endtask

   task automatic test_serial_order();
      send_frame(8'hA5, 3'd7, 2'b10, 1, 1'b0, 1'b0);
   endtask

   task automatic test_reject_saturation();
      send_frame(8'h0F, 3'd3, 2'b11, 0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         send_frame(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 2'b10,
                    $urandom_range(0, 3), 1'b0, 1'b0);
      send_frame(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 2'b11, 0, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      send_frame(8'h5C, 3'd4, 2'b01, 0, 1'b0, 1'b0);
      send_frame(8'h01, 3'd0, 2'b00, 3, 1'b0, 1'b0);
      // Verdict lands on the very edge the timeout would fire
      send_frame(8'h96, 3'd2, 2'b10, TIMEOUT, 1'b0, 1'b0);
   endtask

   task automatic test_start_during_send();
      send_frame(8'h6B, 3'd5, 2'b11, 0, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid_frame();
      ui_in  = 8'hFF;
      len_m1 = 3'd7;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      tests++;
      if (tx_v !== 1'b1) begin
         fails++;
         $display("FAIL mid_frame_start: got tx_v=%b expected 1", tx_v);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      tests++;
      if (uo_out !== 8'h00) begin
         fails++;
         $display("FAIL mid_frame_reset: got %h expected 00", uo_out);
      end
      rst_n     = 1'b1;
      rej_model = 2'b00;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (uo_out !== 8'h00) begin
            fails++;
            $display("FAIL no_resume: got %h expected 00", uo_out);
         end
      end
      send_frame(8'hC3, 3'd7, 2'b10, 0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++)
         send_frame(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                    2'($urandom_range(2, 3)), 0, 1'b0, 1'b0);
   endtask

   task automatic test_start_held();
      send_frame(8'h2D, 3'd2, 2'b11, 1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if (tx_v !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL start_held_retrigger: got tx_v=%b done=%b expected 0 1", tx_v, done);
         end
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n     = 1'b0;
      ena       = 1'b1;
      ui_in     = 8'h00;
      start     = 1'b0;
      len_m1    = 3'd0;
      resp      = 2'b00;
      rej_model = 2'b00;
      test_reset();
      test_approve_2bit();
      test_serial_order();
      test_reject_saturation();
      test_timeout();
      test_start_during_send();
      test_reset_mid_frame();
      test_back_to_back();
      test_start_held();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
